// File: rtl/decode_stage.sv
// ID stage of a 5-stage MIPS-like pipeline: IF/ID register, instruction decode,
// load-use hazard detection with bubble insertion, and a saturating stall counter.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrIn,
  input  logic [31:0]      pcPlus4In,
  input  logic             instrValidIn,
  input  logic             flush,
  input  logic             exMemRead,
  input  logic [4:0]       exDestReg,
  output logic [4:0]       firstRegNumber,
  output logic [4:0]       secondRegNumber,
  output logic [4:0]       destRegNumber,
  output logic [31:0]      immExt,
  output logic [31:0]      pcPlus4Out,
  output logic             regWriteSignal,
  output logic             memRead,
  output logic             memWrite,
  output logic             branch,
  output logic             aluSrc,
  output logic             memToReg,
  output logic [2:0]       aluCtrl,
  output logic             illegal,
  output logic             stall,
  output logic [CNT_W-1:0] stallCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (&value) return value;
    return value + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [31:0]      instr_p1;
  logic [31:0]      pc_plus4_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  logic       legal;
  logic       uses_rt;
  logic [4:0] dest_num;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic       dec_alu_src;
  logic       dec_mem_to_reg;
  logic [2:0] dec_alu_ctrl;
  logic       hazard;
  logic       issue;

  // IF -> ID boundary: flush squashes, a load-use hazard freezes the register
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1    <= NOP_INSTR;
      pc_plus4_p1 <= 32'h0;
      vld_p1      <= 1'b0;
    end else if (flush) begin
      instr_p1    <= NOP_INSTR;
      pc_plus4_p1 <= 32'h0;
      vld_p1      <= 1'b0;
    end else if (!hazard) begin
      instr_p1    <= instrIn;
      pc_plus4_p1 <= pcPlus4In;
      vld_p1      <= instrValidIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (hazard) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign opcode = instr_p1[31:26];
  assign rs     = instr_p1[25:21];
  assign rt     = instr_p1[20:16];
  assign rd     = instr_p1[15:11];
  assign funct  = instr_p1[5:0];

  always_comb begin
    legal          = 1'b0;
    uses_rt        = 1'b0;
    dest_num       = 5'd0;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_branch     = 1'b0;
    dec_alu_src    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_ctrl   = ALU_AND;
    case (opcode)
      OP_RTYPE: begin
        uses_rt  = 1'b1;
        dest_num = rd;
        if (instr_p1 == 32'h0) begin
          // canonical NOP: legal, but writes nothing
          legal = 1'b1;
        end else begin
          legal         = 1'b1;
          dec_reg_write = 1'b1;
          case (funct)
            FN_ADD:  dec_alu_ctrl = ALU_ADD;
            FN_SUB:  dec_alu_ctrl = ALU_SUB;
            FN_AND:  dec_alu_ctrl = ALU_AND;
            FN_OR:   dec_alu_ctrl = ALU_OR;
            FN_SLT:  dec_alu_ctrl = ALU_SLT;
            default: begin
              legal         = 1'b0;
              dec_reg_write = 1'b0;
            end
          endcase
        end
      end
      OP_LW: begin
        legal          = 1'b1;
        dest_num       = rt;
        dec_reg_write  = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_src    = 1'b1;
        dec_alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        legal         = 1'b1;
        uses_rt       = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        legal        = 1'b1;
        uses_rt      = 1'b1;
        dec_branch   = 1'b1;
        dec_alu_ctrl = ALU_SUB;
      end
      OP_ADDI: begin
        legal         = 1'b1;
        dest_num      = rt;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = ALU_ADD;
      end
      default: legal = 1'b0;
    endcase
  end

  // A load in EX whose result the ID instruction needs forces a one-cycle bubble
  assign hazard = vld_p1 & exMemRead & (exDestReg != 5'd0) & ~flush &
                  ((exDestReg == rs) | (uses_rt & (exDestReg == rt)));
  assign issue  = vld_p1 & legal & ~hazard;

  assign firstRegNumber  = rs;
  assign secondRegNumber = rt;
  assign destRegNumber   = dest_num;
  assign immExt          = {{16{instr_p1[15]}}, instr_p1[15:0]};
  assign pcPlus4Out      = pc_plus4_p1;

  assign regWriteSignal = issue & dec_reg_write;
  assign memRead        = issue & dec_mem_read;
  assign memWrite       = issue & dec_mem_write;
  assign branch         = issue & dec_branch;
  assign aluSrc         = issue & dec_alu_src;
  assign memToReg       = issue & dec_mem_to_reg;
  assign aluCtrl        = issue ? dec_alu_ctrl : 3'b000;
  assign illegal        = vld_p1 & ~legal;
  assign stall          = hazard;
  assign stallCount     = stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic, all
// checked against an instruction-level model of the IF/ID stage.
module tb_decode_stage;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      instrIn = '0;
  logic [31:0]      pcPlus4In = '0;
  logic             instrValidIn = 1'b0;
  logic             flush = 1'b0;
  logic             exMemRead = 1'b0;
  logic [4:0]       exDestReg = '0;
  logic [4:0]       firstRegNumber, secondRegNumber, destRegNumber;
  logic [31:0]      immExt, pcPlus4Out;
  logic             regWriteSignal, memRead, memWrite, branch, aluSrc, memToReg;
  logic [2:0]       aluCtrl;
  logic             illegal, stall;
  logic [CNT_W-1:0] stallCount;

  decode_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instrIn(instrIn), .pcPlus4In(pcPlus4In),
    .instrValidIn(instrValidIn), .flush(flush), .exMemRead(exMemRead),
    .exDestReg(exDestReg), .firstRegNumber(firstRegNumber),
    .secondRegNumber(secondRegNumber), .destRegNumber(destRegNumber),
    .immExt(immExt), .pcPlus4Out(pcPlus4Out), .regWriteSignal(regWriteSignal),
    .memRead(memRead), .memWrite(memWrite), .branch(branch), .aluSrc(aluSrc),
    .memToReg(memToReg), .aluCtrl(aluCtrl), .illegal(illegal), .stall(stall),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       first, second, dest;
    logic [31:0]      imm, pc;
    logic             rw, mr, mw, br, as, m2r;
    logic [2:0]       alu;
    logic             ill, stl;
    logic [CNT_W-1:0] cnt;
  } out_t;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] m_instr = '0;
  logic [31:0] m_pc = '0;
  bit          m_valid = 0;
  int          m_cnt = 0;

  function automatic out_t actual();
    out_t a;
    a.first = firstRegNumber; a.second = secondRegNumber; a.dest = destRegNumber;
    a.imm = immExt; a.pc = pcPlus4Out;
    a.rw = regWriteSignal; a.mr = memRead; a.mw = memWrite; a.br = branch;
    a.as = aluSrc; a.m2r = memToReg; a.alu = aluCtrl;
    a.ill = illegal; a.stl = stall; a.cnt = stallCount;
    return a;
  endfunction

  // Expected outputs from the held instruction and the current EX/flush inputs
  function automatic out_t expected();
    out_t e = '0;
    int op = int'(m_instr[31:26]);
    int fn = int'(m_instr[5:0]);
    int rs = int'(m_instr[25:21]);
    int rt = int'(m_instr[20:16]);
    int rd = int'(m_instr[15:11]);
    bit legal = 0, urt = 0, haz;
    logic [5:0] fl = '0;   // rw mr mw br as m2r
    logic [2:0] alu = '0;
    e.first = 5'(rs); e.second = 5'(rt);
    e.imm = {{16{m_instr[15]}}, m_instr[15:0]};
    e.pc = m_pc; e.cnt = CNT_W'(m_cnt);
    if (m_instr == 32'h0) begin
      legal = 1; urt = 1;
    end else if (op == 0) begin
      urt = 1; e.dest = 5'(rd);
      legal = fn inside {32, 34, 36, 37, 42};
      fl = 6'b100000;
      alu = (fn == 32) ? 3'd2 : (fn == 34) ? 3'd6 : (fn == 36) ? 3'd0 :
            (fn == 37) ? 3'd1 : 3'd7;
    end else if (op == 35) begin
      legal = 1; e.dest = 5'(rt); fl = 6'b110011; alu = 3'd2;
    end else if (op == 43) begin
      legal = 1; urt = 1; fl = 6'b001010; alu = 3'd2;
    end else if (op == 4) begin
      legal = 1; urt = 1; fl = 6'b000100; alu = 3'd6;
    end else if (op == 8) begin
      legal = 1; e.dest = 5'(rt); fl = 6'b100010; alu = 3'd2;
    end
    haz = m_valid && exMemRead && exDestReg != 0 && !flush &&
          (int'(exDestReg) == rs || (urt && int'(exDestReg) == rt));
    e.stl = haz;
    e.ill = m_valid && !legal;
    if (m_valid && legal && !haz) begin
      {e.rw, e.mr, e.mw, e.br, e.as, e.m2r} = fl;
      e.alu = alu;
    end
    return e;
  endfunction

  function automatic void model_edge();
    bit s = expected().stl;
    if (reset) begin
      m_instr = 32'h0; m_pc = '0; m_valid = 0; m_cnt = 0;
    end else begin
      if (s && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        m_instr = 32'h0; m_pc = '0; m_valid = 0;
      end else if (!s) begin
        m_instr = instrIn; m_pc = pcPlus4In; m_valid = instrValidIn;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] pc, input logic v,
                       input logic fl, input logic emr, input logic [4:0] edr);
    instrIn = i; pcPlus4In = pc; instrValidIn = v;
    flush = fl; exMemRead = emr; exDestReg = edr;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0: return {6'd0, r[25:6], fns[$urandom_range(0, 4)]};
      1: return {6'd35, r[25:0]};
      2: return {6'd43, r[25:0]};
      3: return {6'd4, r[25:0]};
      4: return {6'd8, r[25:0]};
      5: return r;
      6: return 32'h0;
      default: return {6'd0, r[25:0]};
    endcase
  endfunction

  task automatic test_reset();
    drive($urandom, $urandom, 1'b1, 1'b1, 1'b1, 5'd3);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    compared++;
    if (actual() !== out_t'('0)) begin
      mismatched++;
      $display("FAIL reset_zero: got %h want 0", actual());
    end
    tick();
    compared++;
    if (actual() !== expected()) begin
      mismatched++;
      $display("FAIL reset_idle: got %h want %h", actual(), expected());
    end
  endtask

  task automatic test_add();
    drive(32'h012A4020, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    compared++;
    if ({firstRegNumber, secondRegNumber, destRegNumber, regWriteSignal, aluCtrl, pcPlus4Out}
        !== {5'd9, 5'd10, 5'd8, 1'b1, 3'b010, 32'h44}) begin
      mismatched++;
      $display("FAIL add_decode: got rs=%0d rt=%0d rd=%0d rw=%b alu=%b pc=%h want 9 10 8 1 010 44",
               firstRegNumber, secondRegNumber, destRegNumber, regWriteSignal, aluCtrl, pcPlus4Out);
    end
    compared++;
    if (actual() !== expected()) begin
      mismatched++;
      $display("FAIL add_model: got %h want %h", actual(), expected());
    end
  endtask

  task automatic test_lw();
    drive(32'h8D280004, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(32'h8D28FFFC, 32'h0000_0108, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    compared++;
    if ({memRead, memToReg, aluSrc, regWriteSignal, destRegNumber, immExt}
        !== {4'b1111, 5'd8, 32'h00000004}) begin
      mismatched++;
      $display("FAIL lw_pos: got mr=%b m2r=%b as=%b rw=%b rd=%0d imm=%h want 1 1 1 1 8 00000004",
               memRead, memToReg, aluSrc, regWriteSignal, destRegNumber, immExt);
    end
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    compared++;
    if (immExt !== 32'hFFFFFFFC || actual() !== expected()) begin
      mismatched++;
      $display("FAIL lw_neg: got imm=%h all=%h want imm=fffffffc all=%h",
               immExt, actual(), expected());
    end
  endtask

  task automatic test_hazard();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(32'h010B5020, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(32'h01294820, 32'h0000_0108, 1'b1, 1'b0, 1'b1, 5'd8);
    #1;
    compared++;
    if ({stall, regWriteSignal, aluCtrl} !== {1'b1, 1'b0, 3'b000}) begin
      mismatched++;
      $display("FAIL hazard_bubble: got stall=%b rw=%b alu=%b want 1 0 000",
               stall, regWriteSignal, aluCtrl);
    end
    tick();
    exMemRead = 1'b0;
    #1;
    compared++;
    if ({stallCount, firstRegNumber, secondRegNumber, destRegNumber, pcPlus4Out, stall, regWriteSignal}
        !== {CNT_W'(1), 5'd8, 5'd11, 5'd10, 32'h104, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL hazard_release: got cnt=%0d rs=%0d rt=%0d rd=%0d pc=%h stall=%b rw=%b want 1 8 11 10 104 0 1",
               stallCount, firstRegNumber, secondRegNumber, destRegNumber, pcPlus4Out, stall, regWriteSignal);
    end
    compared++;
    if (actual() !== expected()) begin
      mismatched++;
      $display("FAIL hazard_model: got %h want %h", actual(), expected());
    end
  endtask

  task automatic test_hazard_variants();
    exMemRead = 1'b1; exDestReg = 5'd0;
    #1;
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL hazard_r0: got stall=%b want 0", stall);
    end
    drive(32'hAD280000, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    exMemRead = 1'b1; exDestReg = 5'd8;
    #1;
    compared++;
    if ({stall, memWrite} !== 2'b10) begin
      mismatched++;
      $display("FAIL hazard_sw_rt: got stall=%b mw=%b want 1 0", stall, memWrite);
    end
    drive(32'h21280001, 32'h0000_0204, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    exMemRead = 1'b1; exDestReg = 5'd8;
    #1;
    compared++;
    if ({stall, regWriteSignal, aluSrc, destRegNumber} !== {1'b0, 1'b1, 1'b1, 5'd8}) begin
      mismatched++;
      $display("FAIL hazard_addi_rt: got stall=%b rw=%b as=%b rd=%0d want 0 1 1 8",
               stall, regWriteSignal, aluSrc, destRegNumber);
    end
  endtask

  task automatic test_flush_illegal();
    drive(32'h010B5020, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(32'h012A4020, 32'h0000_0304, 1'b1, 1'b1, 1'b1, 5'd8);
    #1;
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_masks_stall: got stall=%b want 0", stall);
    end
    tick();
    flush = 1'b0;
    #1;
    compared++;
    if ({firstRegNumber, secondRegNumber, pcPlus4Out, stall, regWriteSignal, illegal}
        !== {5'd0, 5'd0, 32'h0, 3'b000} || actual() !== expected()) begin
      mismatched++;
      $display("FAIL flush_nop: got %h want %h", actual(), expected());
    end
    drive(32'hFC000000, 32'h0000_0400, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    instrValidIn = 1'b0;
    #1;
    compared++;
    if ({illegal, regWriteSignal, memRead, memWrite, branch, aluSrc, memToReg, aluCtrl}
        !== {1'b1, 6'b0, 3'b000}) begin
      mismatched++;
      $display("FAIL illegal_op: got ill=%b ctl=%b%b%b%b%b%b alu=%b want 1 000000 000",
               illegal, regWriteSignal, memRead, memWrite, branch, aluSrc, memToReg, aluCtrl);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      instrIn = rand_instr();
      pcPlus4In = $urandom;
      instrValidIn = ($urandom_range(0, 4) != 0);
      flush = ($urandom_range(0, 7) == 0);
      exMemRead = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: exDestReg = m_instr[25:21];
        1: exDestReg = m_instr[20:16];
        default: exDestReg = 5'($urandom);
      endcase
      #1;
      compared++;
      if (actual() !== expected()) begin
        mismatched++;
        $display("FAIL random[%0d]: instr=%h got %h want %h", n, m_instr, actual(), expected());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(32'h010B5020, 32'h0000_0500, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    exMemRead = 1'b1; exDestReg = 5'd8;
    for (int n = 0; n < (1 << CNT_W) + 3; n++) tick();
    compared++;
    if ({stallCount, stall} !== {{CNT_W{1'b1}}, 1'b1} || actual() !== expected()) begin
      mismatched++;
      $display("FAIL stall_saturate: got cnt=%0d stall=%b want %0d 1", stallCount, stall, CNT_MAX);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    compared++;
    if ({stallCount, stall} !== {CNT_W'(0), 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid_stall: got cnt=%0d stall=%b want 0 0", stallCount, stall);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_hazard();
    test_hazard_variants();
    test_flush_illegal();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000000, is the instruction word loaded into the IF/ID register on reset or flush.
REQ-002 Parameter CNT_W, default 16, is the width of the stall event counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instrIn  input  32  fetched instruction from IF.
REQ-006 pcPlus4In  input  32  PC+4 of the fetched instruction.
REQ-007 instrValidIn  input  1  IF presents a valid instruction.
REQ-008 flush  input  1  squash IF/ID contents (taken branch/jump).
REQ-009 exMemRead  input  1  instruction currently in EX is a load.
REQ-010 exDestReg  input  5  destination register of instruction in EX.
REQ-011 firstRegNumber, secondRegNumber  output  5 each  rs/rt fields sent to the register file.
REQ-012 destRegNumber  output  5  rd for R-type, rt for lw/addi, 0 otherwise.
REQ-013 immExt  output  32  sign-extended instr[15:0].
REQ-014 pcPlus4Out  output  32  registered PC+4.
REQ-015 regWriteSignal, memRead, memWrite, branch, aluSrc, memToReg  output  1 each  control signals.
REQ-016 aluCtrl  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-017 illegal  output  1  valid instruction with unsupported opcode/funct.
REQ-018 stall  output  1  hold PC and IF (combinational).
REQ-019 stallCount  output  CNT_W  saturating count of stall cycles.

Function
REQ-020 IF/ID register (instr, pcPlus4, valid) SHALL load instrIn/pcPlus4In/instrValidIn on each rising edge when neither stall nor flush is asserted.
REQ-021 flush SHALL load NOP_INSTR, valid=0 on the next edge, with priority over stall.
REQ-022 stall SHALL hold IF/ID unchanged on the next edge.
REQ-023 Register numbers, immExt, destRegNumber, controls SHALL be combinational from the IF/ID register (zero added latency after capture edge).
REQ-024 Decode: opcode 000000 R-type (funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT), regWrite=1; 100011 lw: regWrite, memRead, memToReg, aluSrc, ADD; 101011 sw: memWrite, aluSrc, ADD; 000100 beq: branch, SUB; 001000 addi: regWrite, aluSrc, ADD.
REQ-025 Any other opcode or R-type funct with valid=1 SHALL assert illegal and zero all controls; the all-zero word SHALL decode as a NOP (controls 0, illegal 0).
REQ-026 usesRt SHALL be 1 for R-type, sw, beq; 0 otherwise.
REQ-027 stall = valid & exMemRead & (exDestReg!=0) & (exDestReg==rs | (usesRt & exDestReg==rt)), and SHALL be 0 while flush is asserted.
REQ-028 While stall=1, all control outputs SHALL be forced 0 (bubble); field outputs remain driven.
REQ-029 stallCount SHALL increment by 1 on each edge where stall=1 and SHALL saturate at all-ones.
REQ-030 valid=0 SHALL force controls, illegal and stall to 0.

Reset
REQ-031 reset SHALL set IF/ID instr=NOP_INSTR, pcPlus4=0, valid=0, stallCount=0, taking priority over flush and stall.
REQ-032 After reset, all outputs SHALL be 0 until a valid instruction is captured.
REQ-033 reset asserted during a stall SHALL clear it on the same edge; next cycle stall=0.

Verification
REQ-034 Reset, then instrIn=0x012A4020 (add $8,$9,$10) valid -> next cycle first=9, second=10, dest=8, regWrite=1, aluCtrl=010.
REQ-035 Capture lw $8,4($9) (0x8D280004) -> memRead=1, memToReg=1, aluSrc=1, dest=8, immExt=0x00000004; 0x8D28FFFC -> immExt=0xFFFFFFFC.
REQ-036 IF/ID holds add $10,$8,$11 with exMemRead=1, exDestReg=8 -> stall=1, controls 0, IF/ID held next edge, stallCount=1; exMemRead=0 -> stall=0, add issues.
REQ-037 Same hazard with exDestReg=0 -> stall=0; sw with exDestReg matching rt -> stall=1; addi with matching rt -> stall=0.
REQ-038 flush and stall asserted together -> IF/ID=NOP, valid=0, stall=0 next cycle; opcode 111111 valid -> illegal=1, controls 0.
REQ-039 Force stall for 2^CNT_W+3 cycles -> stallCount stays all-ones; reset mid-stall -> stallCount=0, stall=0 next cycle.
